traffic_conflict_monitor: RTL and testbench
===========================================

Name: traffic_conflict_monitor

Overview:
- Safety stage directly downstream of the 4-way phase sequencer; it sits between the sequencer outputs and the lamp drivers.
- Passes lamp commands through with one cycle of latency and checks every cycle for illegal encodings, conflicting non-red approaches and skipped yellows.
- On a fault it latches a fault code and drives all approaches in flashing red until an operator clear followed by a clean all-red recovery interval.

Parameters:
- FILTER, 2: consecutive violating cycles needed to latch an encoding or conflict fault (>=1).
- FLASH_HALF, 4: cycles per half-period of flashing red (>=1).
- ALL_RED_HOLD, 6: clean all-red cycles in RECOVER before returning to MONITOR (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- north_in  in  3  sequencer command {Red,Yellow,Green}.
- east_in  in  3  as north_in.
- south_in  in  3  as north_in.
- west_in  in  3  as north_in.
- clear_fault  in  1  operator clear; single-cycle pulse.
- north_lamp  out  3  registered lamp drive {R,Y,G}.
- east_lamp  out  3  as north_lamp.
- south_lamp  out  3  as north_lamp.
- west_lamp  out  3  as north_lamp.
- fault  out  1  high in FAULT and RECOVER.
- fault_code  out  2  0 none, 1 bad encoding, 2 conflict, 3 skipped yellow.

Behaviour:
- One clock; reset is synchronous and active-high, clock port clk, reset port reset.
- Reset (overrides everything, including mid-flash or mid-recover):
  - all lamps 3'b100; fault=0; fault_code=0; state=MONITOR.
  - filter, flash and hold counters = 0; flash phase = on.
  - previous-input registers = 3'b100 each.
- Per-cycle checks on the current inputs:
  - enc_bad: any approach not in {100, 010, 001}.
  - conflict: more than one approach not equal to 100.
  - skip: any approach had previous input 001 and current input 100.
  - Previous-input registers update every cycle in all states.
- Code priority on simultaneous violations: 1 > 2 > 3.
- MONITOR:
  - Lamps <= inputs (1-cycle latency) when no violation is present this cycle; lamps <= all 100 if any violation is present.
  - Filter counter increments on enc_bad|conflict and clears to 0 on a clean cycle.
  - Latch when the counter would reach FILTER: state<=FAULT, fault<=1, fault_code <= code of the violation that cycle.
  - skip latches immediately (no filter) with code 3, unless code 1 or 2 latches in the same cycle.
  - On entering FAULT: flash counter <= 0, phase <= on, lamps <= all 100.
- FAULT:
  - Lamps all 100 while phase is on, all 000 while phase is off.
  - Phase toggles after FLASH_HALF cycles; the flash counter wraps to 0.
  - fault_code is held.
  - clear_fault=1 -> RECOVER: lamps all 100, hold counter <= 0. Otherwise clear_fault is ignored.
- RECOVER:
  - Lamps all 100; fault=1; fault_code held.
  - Any single violating cycle (unfiltered) -> FAULT with the original code retained; flash restarts in the on phase.
  - Hold counter counts clean cycles; when it reaches ALL_RED_HOLD -> MONITOR, fault<=0, fault_code<=0, filter counter 0.
  - Lamps follow inputs from the next cycle.
- clear_fault asserted in MONITOR or RECOVER has no effect.
- All-red inputs (all 100) are legal and never count as a violation.
- Yellow->red and red->green transitions are legal.
- Counter widths are sized with $clog2 of their parameter + 1; no counter overflows.

Test Plan:
- Normal cycle: after reset, drive north 001 x6, 010 x3, then east 001 -> lamps equal the inputs delayed one cycle; fault=0 throughout.
- Glitch filter: north 001 and east 001 for 1 cycle, then a legal pattern -> that lamp cycle all 100, no fault. The same overlap held for 2 cycles -> fault=1, code=2, lamps flash: 4 cycles 100, 4 cycles 000, repeating.
- Bad encoding plus conflict: north 011 and east 001 for 2 cycles -> code=1 (priority over 2).
- Skipped yellow: south 001 then 100 on the next cycle -> FAULT the following cycle, code=3, flashing starts in the on phase.
- Recovery: in FAULT pulse clear_fault, hold inputs all 100 for 6 cycles -> fault=0, code=0, MONITOR. Repeat with a conflict on recover cycle 3 -> back to FAULT with the original code.
- Reset mid-flash during the off phase -> the next cycle shows lamps all 100, fault=0, code=0; clear_fault pulsed in MONITOR changes nothing.

Source files
------------

// File: rtl/traffic_conflict_monitor.sv
// Safety stage between the phase sequencer and the lamp drivers: forwards lamp
// commands with one cycle of latency, latches faults and forces flashing red.
module traffic_conflict_monitor #(
    parameter int unsigned FILTER       = 2,
    parameter int unsigned FLASH_HALF   = 4,
    parameter int unsigned ALL_RED_HOLD = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] north_in,
    input  logic [2:0] east_in,
    input  logic [2:0] south_in,
    input  logic [2:0] west_in,
    input  logic       clear_fault,
    output logic [2:0] north_lamp,
    output logic [2:0] east_lamp,
    output logic [2:0] south_lamp,
    output logic [2:0] west_lamp,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam int unsigned FILT_W  = $clog2(FILTER) + 1;
    localparam int unsigned FLASH_W = $clog2(FLASH_HALF) + 1;
    localparam int unsigned HOLD_W  = $clog2(ALL_RED_HOLD) + 1;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    localparam logic [3:0][2:0] ALL_RED  = {4{RED}};
    localparam logic [3:0][2:0] ALL_DARK = {4{3'b000}};

    localparam logic [1:0] CODE_NONE     = 2'd0;
    localparam logic [1:0] CODE_ENCODING = 2'd1;
    localparam logic [1:0] CODE_CONFLICT = 2'd2;
    localparam logic [1:0] CODE_SKIP     = 2'd3;

    typedef enum logic [1:0] {
        MONITOR = 2'd0,
        FAULT   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t               state;
    logic [3:0][2:0]      cur;
    logic [3:0][2:0]      prev;
    logic [3:0][2:0]      lamps;
    logic [FILT_W-1:0]    filt_cnt;
    logic [FLASH_W-1:0]   flash_cnt;
    logic [HOLD_W-1:0]    hold_cnt;
    logic                 phase_on;

    logic                 enc_bad;
    logic                 conflict;
    logic                 skip;
    logic                 filtered_viol;
    logic [2:0]           nonred_cnt;
    logic [FILT_W-1:0]    filt_inc;
    logic [HOLD_W-1:0]    hold_inc;

    assign cur = {west_in, south_in, east_in, north_in};

    assign north_lamp = lamps[0];
    assign east_lamp  = lamps[1];
    assign south_lamp = lamps[2];
    assign west_lamp  = lamps[3];

    // Per-cycle legality checks on the incoming commands.
    always_comb begin
        enc_bad    = 1'b0;
        skip       = 1'b0;
        nonred_cnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (!(cur[i] == RED || cur[i] == YELLOW || cur[i] == GREEN)) begin
                enc_bad = 1'b1;
            end
            if (cur[i] != RED) begin
                nonred_cnt = nonred_cnt + 3'd1;
            end
            if (prev[i] == GREEN && cur[i] == RED) begin
                skip = 1'b1;
            end
        end
        conflict      = nonred_cnt > 3'd1;
        filtered_viol = enc_bad | conflict;
    end

    assign filt_inc = filt_cnt + FILT_W'(1);
    assign hold_inc = hold_cnt + HOLD_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= MONITOR;
            lamps      <= ALL_RED;
            prev       <= ALL_RED;
            fault      <= 1'b0;
            fault_code <= CODE_NONE;
            filt_cnt   <= '0;
            flash_cnt  <= '0;
            hold_cnt   <= '0;
            phase_on   <= 1'b1;
        end else begin
            prev <= cur;
            case (state)
                MONITOR: begin
                    filt_cnt <= filtered_viol ? filt_inc : '0;
                    if (filtered_viol && filt_inc == FILT_W'(FILTER)) begin
                        state      <= FAULT;
                        fault      <= 1'b1;
                        fault_code <= enc_bad ? CODE_ENCODING : CODE_CONFLICT;
                        filt_cnt   <= '0;
                        flash_cnt  <= '0;
                        phase_on   <= 1'b1;
                        lamps      <= ALL_RED;
                    end else if (skip) begin
                        state      <= FAULT;
                        fault      <= 1'b1;
                        fault_code <= CODE_SKIP;
                        filt_cnt   <= '0;
                        flash_cnt  <= '0;
                        phase_on   <= 1'b1;
                        lamps      <= ALL_RED;
                    end else begin
                        lamps <= filtered_viol ? ALL_RED : cur;
                    end
                end
                FAULT: begin
                    if (clear_fault) begin
                        state    <= RECOVER;
                        hold_cnt <= '0;
                        lamps    <= ALL_RED;
                    end else if (flash_cnt == FLASH_W'(FLASH_HALF - 1)) begin
                        // Half-period complete: flip phase and show the new one.
                        flash_cnt <= '0;
                        phase_on  <= ~phase_on;
                        lamps     <= phase_on ? ALL_DARK : ALL_RED;
                    end else begin
                        flash_cnt <= flash_cnt + FLASH_W'(1);
                        lamps     <= phase_on ? ALL_RED : ALL_DARK;
                    end
                end
                RECOVER: begin
                    lamps <= ALL_RED;
                    if (filtered_viol || skip) begin
                        state     <= FAULT;
                        flash_cnt <= '0;
                        phase_on  <= 1'b1;
                    end else if (hold_inc == HOLD_W'(ALL_RED_HOLD)) begin
                        state      <= MONITOR;
                        fault      <= 1'b0;
                        fault_code <= CODE_NONE;
                        filt_cnt   <= '0;
                        hold_cnt   <= '0;
                    end else begin
                        hold_cnt <= hold_inc;
                    end
                end
                default: begin
                    state <= MONITOR;
                    lamps <= ALL_RED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Scoreboard bench for traffic_conflict_monitor: a behavioural model pushes the
// expected lamps/fault/code per driven cycle, popped after the clock edge.
module tb_traffic_conflict_monitor;

    localparam int unsigned FILTER       = 2;
    localparam int unsigned FLASH_HALF   = 4;
    localparam int unsigned ALL_RED_HOLD = 6;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] north_in, east_in, south_in, west_in;
    logic       clear_fault;
    logic [2:0] north_lamp, east_lamp, south_lamp, west_lamp;
    logic       fault;
    logic [1:0] fault_code;

    traffic_conflict_monitor #(
        .FILTER(FILTER), .FLASH_HALF(FLASH_HALF), .ALL_RED_HOLD(ALL_RED_HOLD)
    ) dut (
        .clk(clk), .reset(reset),
        .north_in(north_in), .east_in(east_in), .south_in(south_in), .west_in(west_in),
        .clear_fault(clear_fault),
        .north_lamp(north_lamp), .east_lamp(east_lamp),
        .south_lamp(south_lamp), .west_lamp(west_lamp),
        .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] lamps;
        logic        fault;
        logic [1:0]  code;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: mode 0 monitor, 1 fault, 2 recover; m_t counts cycles since fault entry.
    int         m_mode, m_filt, m_t, m_hold;
    logic [1:0] m_code;
    logic [2:0] m_prev[4];
    logic [2:0] m_lamp[4];

    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic bit legal(input logic [2:0] v);
        return v == R || v == Y || v == G;
    endfunction

    task automatic model_step(input logic [2:0] in[4], input logic clr, input logic rst);
        bit enc, conf, sk, viol;
        int nr;
        exp_t e;
        if (rst) begin
            m_mode = 0; m_filt = 0; m_t = 0; m_hold = 0; m_code = 2'd0;
            for (int i = 0; i < 4; i++) begin
                m_prev[i] = R;
                m_lamp[i] = R;
            end
        end else begin
            enc = 0; sk = 0; nr = 0;
            for (int i = 0; i < 4; i++) begin
                if (!legal(in[i])) enc = 1;
                if (in[i] != R) nr++;
                if (m_prev[i] == G && in[i] == R) sk = 1;
            end
            conf = nr > 1;
            viol = enc || conf;
            case (m_mode)
                0: begin
                    m_filt = viol ? m_filt + 1 : 0;
                    if ((viol && m_filt >= FILTER) || sk) begin
                        m_code = (viol && m_filt >= FILTER) ? (enc ? 2'd1 : 2'd2) : 2'd3;
                        m_mode = 1; m_t = 0; m_filt = 0;
                        for (int i = 0; i < 4; i++) m_lamp[i] = R;
                    end else begin
                        for (int i = 0; i < 4; i++) m_lamp[i] = viol ? R : in[i];
                    end
                end
                1: begin
                    if (clr) begin
                        m_mode = 2; m_hold = 0;
                        for (int i = 0; i < 4; i++) m_lamp[i] = R;
                    end else begin
                        m_t++;
                        for (int i = 0; i < 4; i++)
                            m_lamp[i] = ((m_t / FLASH_HALF) % 2 == 0) ? R : 3'b000;
                    end
                end
                default: begin
                    for (int i = 0; i < 4; i++) m_lamp[i] = R;
                    if (viol || sk) begin
                        m_mode = 1; m_t = 0;
                    end else begin
                        m_hold++;
                        if (m_hold == ALL_RED_HOLD) begin
                            m_mode = 0; m_code = 2'd0; m_filt = 0;
                        end
                    end
                end
            endcase
            for (int i = 0; i < 4; i++) m_prev[i] = in[i];
        end
        e.lamps = {m_lamp[0], m_lamp[1], m_lamp[2], m_lamp[3]};
        e.fault = (m_mode != 0);
        e.code  = m_code;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of stimulus, record expectation, then compare after the edge.
    task automatic cycle(input logic [2:0] n, input logic [2:0] e_, input logic [2:0] s,
                         input logic [2:0] w, input logic clr, input logic rst);
        logic [2:0] in[4];
        exp_t ex;
        north_in = n; east_in = e_; south_in = s; west_in = w;
        clear_fault = clr; reset = rst;
        in[0] = n; in[1] = e_; in[2] = s; in[3] = w;
        model_step(in, clr, rst);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq("queue_empty", 12'd1, 12'd0);
        end else begin
            ex = exp_q.pop_front();
            check_eq("lamps", {north_lamp, east_lamp, south_lamp, west_lamp}, ex.lamps);
            check_eq("fault", 12'(fault), 12'(ex.fault));
            check_eq("fault_code", 12'(fault_code), 12'(ex.code));
        end
    endtask

    task automatic red(input int n);
        repeat (n) cycle(R, R, R, R, 1'b0, 1'b0);
    endtask

    initial begin
        logic [2:0] pat[4];
        north_in = R; east_in = R; south_in = R; west_in = R;
        clear_fault = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        cycle(R, R, R, R, 1'b0, 1'b1);
        cycle(G, Y, 3'b111, R, 1'b1, 1'b1);

        // Normal sequence, no faults expected.
        repeat (6) cycle(G, R, R, R, 1'b0, 1'b0);
        repeat (3) cycle(Y, R, R, R, 1'b0, 1'b0);
        repeat (4) cycle(R, G, R, R, 1'b0, 1'b0);
        repeat (2) cycle(R, Y, R, R, 1'b0, 1'b0);
        red(2);

        // One-cycle overlap is filtered; two cycles latches a conflict.
        cycle(G, G, R, R, 1'b0, 1'b0);
        repeat (2) cycle(G, R, R, R, 1'b0, 1'b0);
        repeat (2) cycle(Y, R, R, R, 1'b0, 1'b0);
        red(1);
        cycle(G, R, R, R, 1'b0, 1'b0);
        repeat (2) cycle(G, G, R, R, 1'b0, 1'b0);
        red(12);
        cycle(R, R, R, R, 1'b1, 1'b0);
        red(8);

        // Bad encoding with conflict takes code 1; re-fault during recovery keeps it.
        repeat (2) cycle(3'b011, G, R, R, 1'b0, 1'b0);
        red(5);
        cycle(R, R, R, R, 1'b1, 1'b0);
        red(2);
        cycle(G, G, R, R, 1'b0, 1'b0);
        red(6);
        cycle(R, R, R, R, 1'b1, 1'b0);
        red(7);

        // Skipped yellow latches immediately; reset in the off phase; clear in MONITOR ignored.
        repeat (2) cycle(R, R, G, R, 1'b0, 1'b0);
        red(6);
        cycle(R, R, R, R, 1'b0, 1'b1);
        cycle(R, G, R, R, 1'b1, 1'b0);
        repeat (2) cycle(R, G, R, R, 1'b0, 1'b0);
        cycle(R, Y, R, R, 1'b1, 1'b0);
        red(2);

        // Randomised mix of legal phases, glitches, clears and occasional resets.
        for (int k = 0; k < 4; k++) pat[k] = R;
        for (int c = 0; c < 600; c++) begin
            int mode;
            mode = $urandom_range(0, 19);
            if (mode < 3) begin
                for (int k = 0; k < 4; k++) pat[k] = R;
                pat[$urandom_range(0, 3)] = ($urandom_range(0, 1) == 1) ? G : Y;
            end else if (mode == 3) begin
                for (int k = 0; k < 4; k++) pat[k] = R;
            end else if (mode == 4) begin
                pat[$urandom_range(0, 3)] = G;
            end else if (mode == 5) begin
                pat[$urandom_range(0, 3)] = 3'($urandom_range(0, 7));
            end
            cycle(pat[0], pat[1], pat[2], pat[3],
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 99) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
